// File: rtl/demux_buf_if.sv
// Handshake bundle for demux_buf: one producer stream in, two consumer streams out,
// plus the per-path delivered-word counters.
interface demux_buf_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] in_put;
    logic             select;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_put1;
    logic             out_valid1;
    logic             out_ready1;
    logic [WIDTH-1:0] out_put2;
    logic             out_valid2;
    logic             out_ready2;
    logic [CNT_W-1:0] count1;
    logic [CNT_W-1:0] count2;

    modport master (
        output in_put, select, in_valid, out_ready1, out_ready2,
        input  in_ready, out_put1, out_valid1, out_put2, out_valid2, count1, count2
    );

    modport slave (
        input  in_put, select, in_valid, out_ready1, out_ready2,
        output in_ready, out_put1, out_valid1, out_put2, out_valid2, count1, count2
    );
endinterface

// File: rtl/demux_buf.sv
// Buffered 1-to-2 demux: select=1 steers to path 1, select=0 to path 2; each path has
// its own FWFT FIFO and delivered-word counter so one stalled sink never blocks the other.

// One output path: FWFT FIFO plus pop counter.
module demux_buf_path #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop_req,
    output logic             full,
    output logic             valid,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0]   OCC_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]              occ_q, occ_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        pop;

    always_comb begin
        valid    = (occ_q != '0);
        full     = (occ_q == OCC_FULL);
        pop      = pop_req & valid;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        // push is already qualified by !full upstream, so no overwrite guard here
        if (push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            cnt_d    = cnt_q + CNT_ONE;
        end
        occ_d = occ_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        head  = valid ? mem_q[rd_ptr_q] : '0;
        count = cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: head is masked to zero whenever occupancy is zero.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

module demux_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    demux_buf_if.slave  bus
);
    localparam int NUM_PATHS = 2;

    logic [NUM_PATHS-1:0]            push;
    logic [NUM_PATHS-1:0]            pop_req;
    logic [NUM_PATHS-1:0]            full;
    logic [NUM_PATHS-1:0]            valid;
    logic [NUM_PATHS-1:0][WIDTH-1:0] head;
    logic [NUM_PATHS-1:0][CNT_W-1:0] count;
    logic                            in_ready;

    // Index 0 is path 1 (select=1), index 1 is path 2 (select=0).
    // in_ready depends only on select and registered occupancy, never on out_ready.
    always_comb begin
        in_ready = bus.select ? ~full[0] : ~full[1];
        push[0]  = bus.in_valid & in_ready & bus.select;
        push[1]  = bus.in_valid & in_ready & ~bus.select;
        pop_req  = {bus.out_ready2, bus.out_ready1};
    end

    for (genvar p = 0; p < NUM_PATHS; p++) begin : g_path
        demux_buf_path #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .CNT_W (CNT_W)
        ) u_path (
            .clk     (clk),
            .rst     (rst),
            .push    (push[p]),
            .wdata   (bus.in_put),
            .pop_req (pop_req[p]),
            .full    (full[p]),
            .valid   (valid[p]),
            .head    (head[p]),
            .count   (count[p])
        );
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_put1   = head[0];
    assign bus.out_valid1 = valid[0];
    assign bus.count1     = count[0];
    assign bus.out_put2   = head[1];
    assign bus.out_valid2 = valid[1];
    assign bus.count2     = count[1];
endmodule

// File: tb/tb_demux_buf.sv
// Bench for demux_buf: directed scenarios plus a random run, all checked against a
// queue-based model of the two paths.
module tb_demux_buf;
    localparam int WIDTH = 32;
    localparam int DEPTH = 2;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [WIDTH-1:0] q1[$];
    logic [WIDTH-1:0] q2[$];
    logic [CNT_W-1:0] m_cnt1 = '0;
    logic [CNT_W-1:0] m_cnt2 = '0;

    demux_buf_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    demux_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Advance one clock; the model applies the handshakes seen just before the edge.
    task automatic tick();
        logic             r, acc, p1, p2, sel;
        logic [WIDTH-1:0] d;
        r   = rst;
        sel = bus.select;
        d   = bus.in_put;
        acc = bus.in_valid && (sel ? (q1.size() < DEPTH) : (q2.size() < DEPTH));
        p1  = bus.out_ready1 && (q1.size() > 0);
        p2  = bus.out_ready2 && (q2.size() > 0);
        @(posedge clk);
        #1;
        if (r) begin
            q1.delete(); q2.delete(); m_cnt1 = '0; m_cnt2 = '0;
        end else begin
            if (p1) begin void'(q1.pop_front()); m_cnt1 = m_cnt1 + 1'b1; end
            if (p2) begin void'(q2.pop_front()); m_cnt2 = m_cnt2 + 1'b1; end
            if (acc) begin
                if (sel) q1.push_back(d);
                else     q2.push_back(d);
            end
        end
    endtask

    task automatic idle();
        bus.in_valid = 1'b0; bus.select = 1'b1; bus.in_put = '0;
        bus.out_ready1 = 1'b0; bus.out_ready2 = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1; tick(); rst = 1'b0;
        checks++; if (bus.out_valid1 !== 1'b0) begin errors++; $display("FAIL rst_valid1 got %b exp 0", bus.out_valid1); end
        checks++; if (bus.out_valid2 !== 1'b0) begin errors++; $display("FAIL rst_valid2 got %b exp 0", bus.out_valid2); end
        checks++; if (bus.out_put1 !== '0) begin errors++; $display("FAIL rst_put1 got %0h exp 0", bus.out_put1); end
        checks++; if (bus.out_put2 !== '0) begin errors++; $display("FAIL rst_put2 got %0h exp 0", bus.out_put2); end
        checks++; if (bus.count1 !== '0) begin errors++; $display("FAIL rst_count1 got %0d exp 0", bus.count1); end
        checks++; if (bus.count2 !== '0) begin errors++; $display("FAIL rst_count2 got %0d exp 0", bus.count2); end
        bus.select = 1'b1; #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_sel1 got %b exp 1", bus.in_ready); end
        bus.select = 1'b0; #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_sel0 got %b exp 1", bus.in_ready); end
    endtask

    task automatic test_routing();
        bus.out_ready1 = 1'b1; bus.out_ready2 = 1'b1;
        bus.in_valid = 1'b1; bus.select = 1'b1; bus.in_put = 32'd67;
        tick();
        checks++; if (bus.out_valid1 !== 1'b1 || bus.out_put1 !== 32'd67) begin errors++; $display("FAIL route_p1 got v=%b d=%0d exp v=1 d=67", bus.out_valid1, bus.out_put1); end
        checks++; if (bus.out_valid2 !== 1'b0) begin errors++; $display("FAIL route_p2_idle got %b exp 0", bus.out_valid2); end
        bus.select = 1'b0; bus.in_put = 32'd0;
        tick();
        checks++; if (bus.out_valid1 !== 1'b0) begin errors++; $display("FAIL route_p1_once got %b exp 0", bus.out_valid1); end
        checks++; if (bus.out_valid2 !== 1'b1 || bus.out_put2 !== 32'd0) begin errors++; $display("FAIL route_p2 got v=%b d=%0d exp v=1 d=0", bus.out_valid2, bus.out_put2); end
        bus.in_valid = 1'b0;
        tick();
        checks++; if (bus.out_valid2 !== 1'b0) begin errors++; $display("FAIL route_p2_once got %b exp 0", bus.out_valid2); end
        checks++; if (bus.count1 !== 4'd1 || bus.count1 !== m_cnt1) begin errors++; $display("FAIL route_count1 got %0d exp 1", bus.count1); end
        checks++; if (bus.count2 !== 4'd1 || bus.count2 !== m_cnt2) begin errors++; $display("FAIL route_count2 got %0d exp 1", bus.count2); end
        idle();
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] w1, w2, w3;
        w1 = $urandom; w2 = $urandom; w3 = $urandom;
        idle();
        bus.in_valid = 1'b1; bus.select = 1'b1;
        bus.in_put = w1; tick();
        bus.in_put = w2; tick();
        bus.in_put = w3; #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b exp 0", bus.in_ready); end
        bus.select = 1'b0; #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_other_ready got %b exp 1", bus.in_ready); end
        bus.in_valid = 1'b0; bus.select = 1'b1;
        bus.in_valid = 1'b1; tick();  // third word offered while full: refused
        bus.in_valid = 1'b0;
        checks++; if (bus.out_put1 !== w1 || q1.size() != 2) begin errors++; $display("FAIL bp_head1 got %0h exp %0h", bus.out_put1, w1); end
        bus.out_ready1 = 1'b1; tick();
        checks++; if (bus.out_valid1 !== 1'b1 || bus.out_put1 !== w2) begin errors++; $display("FAIL bp_head2 got v=%b %0h exp v=1 %0h", bus.out_valid1, bus.out_put1, w2); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back got %b exp 1", bus.in_ready); end
        tick();
        checks++; if (bus.out_valid1 !== 1'b0) begin errors++; $display("FAIL bp_no_w3 got %b exp 0", bus.out_valid1); end
        checks++; if (bus.count1 !== m_cnt1) begin errors++; $display("FAIL bp_count1 got %0d exp %0d", bus.count1, m_cnt1); end
        idle();
    endtask

    task automatic test_independence();
        logic [WIDTH-1:0] f0, f1, w;
        logic [CNT_W-1:0] base1, base2;
        f0 = $urandom; f1 = $urandom;
        idle();
        bus.in_valid = 1'b1; bus.select = 1'b0;
        bus.in_put = f0; tick();
        bus.in_put = f1; tick();
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL ind_p2_full got %b exp 0", bus.in_ready); end
        base1 = m_cnt1; base2 = m_cnt2;
        bus.out_ready1 = 1'b1; bus.select = 1'b1;
        for (int i = 0; i < 10; i++) begin
            w = $urandom; bus.in_put = w;
            tick();
            checks++; if (bus.out_valid1 !== 1'b1 || bus.out_put1 !== w) begin errors++; $display("FAIL ind_stream[%0d] got v=%b %0h exp v=1 %0h", i, bus.out_valid1, bus.out_put1, w); end
        end
        bus.in_valid = 1'b0; tick();
        checks++; if (bus.count1 !== CNT_W'(base1 + 4'd10)) begin errors++; $display("FAIL ind_count1 got %0d exp %0d", bus.count1, CNT_W'(base1 + 4'd10)); end
        checks++; if (bus.count2 !== base2) begin errors++; $display("FAIL ind_count2 got %0d exp %0d", bus.count2, base2); end
        checks++; if (bus.out_valid2 !== 1'b1 || bus.out_put2 !== f0) begin errors++; $display("FAIL ind_p2_head got v=%b %0h exp v=1 %0h", bus.out_valid2, bus.out_put2, f0); end
        bus.out_ready1 = 1'b0; bus.out_ready2 = 1'b1; tick();
        checks++; if (bus.out_put2 !== f1) begin errors++; $display("FAIL ind_p2_second got %0h exp %0h", bus.out_put2, f1); end
        tick();
        checks++; if (bus.out_valid2 !== 1'b0) begin errors++; $display("FAIL ind_p2_drained got %b exp 0", bus.out_valid2); end
        idle();
    endtask

    task automatic test_push_pop();
        logic [WIDTH-1:0] a, b;
        a = $urandom; b = $urandom;
        idle();
        bus.in_valid = 1'b1; bus.select = 1'b1; bus.in_put = a; tick();
        bus.in_put = b; bus.out_ready1 = 1'b1; tick();
        checks++; if (bus.out_valid1 !== 1'b1 || bus.out_put1 !== b) begin errors++; $display("FAIL pp_head got v=%b %0h exp v=1 %0h", bus.out_valid1, bus.out_put1, b); end
        bus.in_valid = 1'b0; tick();
        checks++; if (bus.out_valid1 !== 1'b0) begin errors++; $display("FAIL pp_occ1 got %b exp 0", bus.out_valid1); end
        idle();
    endtask

    task automatic test_counter_wrap();
        idle();
        rst = 1'b1; tick(); rst = 1'b0;
        bus.select = 1'b0; bus.out_ready2 = 1'b1; bus.in_valid = 1'b1;
        for (int k = 0; k <= 17; k++) begin
            bus.in_put = $urandom;
            if (k == 17) bus.in_valid = 1'b0;
            tick();
            checks++; if (bus.count2 !== CNT_W'(k % 16) || bus.count2 !== m_cnt2) begin errors++; $display("FAIL wrap_count2[%0d] got %0d exp %0d", k, bus.count2, k % 16); end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        idle();
        bus.in_valid = 1'b1;
        bus.select = 1'b1; bus.in_put = $urandom; tick();
        bus.select = 1'b0; bus.in_put = $urandom; tick();
        bus.select = 1'b1; bus.out_ready1 = 1'b1; bus.out_ready2 = 1'b1;
        rst = 1'b1; tick(); rst = 1'b0;
        idle();
        checks++; if (bus.out_valid1 !== 1'b0 || bus.out_valid2 !== 1'b0) begin errors++; $display("FAIL mid_valid got %b%b exp 00", bus.out_valid1, bus.out_valid2); end
        checks++; if (bus.out_put1 !== '0 || bus.out_put2 !== '0) begin errors++; $display("FAIL mid_put got %0h %0h exp 0 0", bus.out_put1, bus.out_put2); end
        checks++; if (bus.count1 !== '0 || bus.count2 !== '0) begin errors++; $display("FAIL mid_count got %0d %0d exp 0 0", bus.count1, bus.count2); end
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready1 got %b exp 1", bus.in_ready); end
        bus.select = 1'b0; #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready0 got %b exp 1", bus.in_ready); end
        tick();
        checks++; if (bus.out_valid1 !== 1'b0 || bus.out_valid2 !== 1'b0) begin errors++; $display("FAIL mid_nothing_accepted got %b%b exp 00", bus.out_valid1, bus.out_valid2); end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] e1, e2;
        logic             er;
        idle();
        for (int n = 0; n < 400; n++) begin
            bus.in_valid   = ($urandom_range(0, 3) != 0);
            bus.select     = $urandom_range(0, 1);
            bus.in_put     = $urandom;
            bus.out_ready1 = ($urandom_range(0, 2) != 0);
            bus.out_ready2 = ($urandom_range(0, 2) == 0);
            #1;
            er = bus.select ? (q1.size() < DEPTH) : (q2.size() < DEPTH);
            checks++; if (bus.in_ready !== er) begin errors++; $display("FAIL rnd_ready[%0d] got %b exp %b", n, bus.in_ready, er); end
            tick();
            e1 = (q1.size() > 0) ? q1[0] : '0;
            e2 = (q2.size() > 0) ? q2[0] : '0;
            checks++; if (bus.out_valid1 !== (q1.size() > 0) || bus.out_put1 !== e1) begin errors++; $display("FAIL rnd_p1[%0d] got v=%b %0h exp v=%b %0h", n, bus.out_valid1, bus.out_put1, q1.size() > 0, e1); end
            checks++; if (bus.out_valid2 !== (q2.size() > 0) || bus.out_put2 !== e2) begin errors++; $display("FAIL rnd_p2[%0d] got v=%b %0h exp v=%b %0h", n, bus.out_valid2, bus.out_put2, q2.size() > 0, e2); end
            checks++; if (bus.count1 !== m_cnt1 || bus.count2 !== m_cnt2) begin errors++; $display("FAIL rnd_count[%0d] got %0d %0d exp %0d %0d", n, bus.count1, bus.count2, m_cnt1, m_cnt2); end
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_routing();
        test_backpressure();
        test_independence();
        test_push_pop();
        test_counter_wrap();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/demux_buf.md
# demux_buf

Buffered 1-to-2 demultiplexer that steers a 32-bit word to one of two consumers under a select bit, using the same select polarity as the datapath `mux` (select=1 → path 1, select=0 → path 2). Each destination has its own small first-word-fall-through FIFO with valid/ready handshakes on both sides. Each destination also has a delivered-word counter. The block sits between a result producer (ALU/load path) and two independent sinks (e.g. write-back and store/forwarding paths), so a stall on one sink does not block the other.

## Interface
- WIDTH, 32, data width
- DEPTH, 2, entries per output FIFO; power of two, ≥2
- CNT_W, 16, width of each delivered-word counter
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_put  in  WIDTH  input word
- select  in  1  destination: 1 → path 1, 0 → path 2
- in_valid  in  1  producer offers in_put/select this cycle
- in_ready  out  1  block accepts the offered word this cycle
- out_put1  out  WIDTH  path-1 head word
- out_valid1  out  1  path-1 FIFO non-empty
- out_ready1  in  1  path-1 consumer takes head this cycle
- out_put2  out  WIDTH  path-2 head word
- out_valid2  out  1  path-2 FIFO non-empty
- out_ready2  in  1  path-2 consumer takes head this cycle
- count1  out  CNT_W  words delivered on path 1
- count2  out  CNT_W  words delivered on path 2

## Operation
- Input transfer (push): `in_valid & in_ready` at a rising edge. The word is written to FIFO1 if select=1, else FIFO2.
- `in_ready` = !full of the FIFO addressed by the *current* select. It is a combinational function of select and the registered occupancy only; there is no path from out_ready*.
- The producer may change select or in_put while in_ready=0. No stability rule applies; only the values at the handshake edge matter.
- Output transfer (pop) on path k: `out_valid_k & out_ready_k` at a rising edge. The FIFO advances to the next entry.
- out_valid_k = occupancy_k ≠ 0. out_put_k = head entry when valid, else 0.
- out_ready_k while out_valid_k=0 is ignored: no pop and no count change.
- Push and pop on the same FIFO in one cycle:
  - When not full, both occur and occupancy is unchanged.
  - When full, only the pop occurs (in_ready was 0).
- Push to one path and pop from the other in the same cycle are fully independent.
- Ordering is preserved per path. There is no ordering relation between paths.
- Occupancy per FIFO ranges 0..DEPTH. Read/write pointers wrap modulo DEPTH.
- count_k increments by 1 on every pop of path k. It wraps from 2^CNT_W−1 to 0 with no saturation or flag.
- Reset (any cycle, including mid-transfer) has priority over all handshakes in that cycle:
  - both FIFOs emptied, contents discarded;
  - counters cleared.

## Timing
- Reset values (cycle after rst sampled high):
  - out_valid1 = out_valid2 = 0
  - out_put1 = out_put2 = 0
  - count1 = count2 = 0
  - in_ready = 1 for either select
- Latency: a word pushed at edge N is visible on out_put_k with out_valid_k=1 from edge N (the following cycle). No bypass occurs within the push cycle.
- Throughput: 1 word/cycle per path when the consumer holds out_ready_k=1. This holds even at DEPTH occupancy, because the pop frees space for the next cycle.
- The full-to-ready transition is visible in the cycle after the freeing pop, since in_ready does not look at out_ready.
- count_k updates at the pop edge and is visible the next cycle.

## Test plan
- **Reset and basic routing:** assert rst 1 cycle, then push 67 with select=1 and 0 with select=0, out_ready1/2=1.
  - Required: out_put1=67 with out_valid1=1 for exactly one cycle.
  - Required: out_put2=0 with out_valid2=1 for exactly one cycle.
  - Required: count1=1, count2=1.
- **Full/backpressure:** out_ready1=0, push 3 words with select=1 (DEPTH=2).
  - Required: first two accepted; in_ready=0 on the third.
  - Required: with select=0 that same cycle, in_ready=1.
  - Then raise out_ready1: required words 1 and 2 emerge in order, and in_ready (select=1) returns to 1 in the cycle after the first pop.
- **Independence:** hold out_ready2=0 with FIFO2 full; stream 10 words to path 1 with out_ready1=1.
  - Required: all 10 delivered at 1/cycle, count1=10, FIFO2 contents and count2 unchanged.
- **Simultaneous push/pop:** FIFO1 holding 1 word, push and pop path 1 in the same cycle.
  - Required: occupancy stays 1, out_valid1 stays 1, new head is the pushed word.
- **Counter wrap:** CNT_W=4, deliver 17 words on path 2.
  - Required: count2 sequence reaches 15, then 0, then 1.
- **Reset mid-operation:** both FIFOs partially filled, rst asserted in a cycle with in_valid and out_ready high.
  - Required: nothing is accepted or counted in that cycle.
  - Required next cycle: all outputs at reset values.
